// File: rtl/core_ctrl_seq.sv
// core_ctrl_seq: single-start layer sequencer driving core.inst; CORE_CTRL_ACC_PHASE_EN adds the output-accumulation pass
module core_ctrl_seq #(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int I_DIM = 8,
  parameter int K_DIM = 3,
  parameter logic [10:0] W_BASE = 11'h400,
  parameter int GAP_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        acc_clr,
  output logic        out_valid,
  output logic [10:0] out_idx,
  output logic        busy,
  output logic        done
);
  localparam int LEN_NIJ = I_DIM * I_DIM;
  localparam int LEN_KIJ = K_DIM * K_DIM;
  localparam logic [3:0] S_IDLE = 4'd0, S_WL0 = 4'd1, S_WLD = 4'd2, S_GAP = 4'd3, S_XL0 = 4'd4;
  localparam logic [3:0] S_EXE = 4'd5, S_EGAP = 4'd6, S_DWT = 4'd7, S_DRN = 4'd8, S_FIN = 4'd9;
`ifdef CORE_CTRL_ACC_PHASE_EN
  localparam int O_DIM = I_DIM - K_DIM + 1;
  localparam int LEN_ONIJ = O_DIM * O_DIM;
  localparam logic [3:0] S_ACC = 4'd10;
  localparam logic [3:0] S_POST = S_ACC;
  localparam logic [15:0] N_KIJ = 16'(LEN_KIJ), N_ACC_END = 16'(LEN_KIJ + 1), N_OV = 16'(LEN_KIJ + 2);
  localparam logic [7:0] KJ_LAST = 8'(K_DIM - 1);
  localparam logic [10:0] OX_LAST = 11'(O_DIM - 1), ONIJ_LAST = 11'(LEN_ONIJ - 1);
  localparam logic [10:0] A_NXT = 11'(LEN_NIJ + 1), A_ROW = 11'(LEN_NIJ + I_DIM - K_DIM + 1), A_K = 11'(K_DIM);
`else
  localparam logic [3:0] S_POST = S_FIN;
`endif
  localparam logic [15:0] N_COL = 16'(COL), N_WLD = 16'(2 * COL - 1), N_GAP = 16'(GAP_CYC - 1), N_NIJ = 16'(LEN_NIJ);
  localparam logic [10:0] A_COL = 11'(COL), A_NIJ = 11'(LEN_NIJ), KIJ_LAST = 11'(LEN_KIJ - 1);
  localparam logic [33:0] IDLE_INST = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  if (LEN_KIJ * LEN_NIJ > 1024 || int'(W_BASE) + LEN_KIJ * COL > 2048 || ROW < 1) begin : g_bad_cfg
    $error("core_ctrl_seq: layer does not fit the memory map");
  end

  logic [3:0]  state_q, state_d;
  logic [15:0] t_q, t_d;
  logic [10:0] kij_q, kij_d, wb_q, wb_d, pb_q, pb_d;
  logic [33:0] inst_q, inst_d;
  logic        acc_clr_q, acc_clr_d, out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic [10:0] out_idx_q, out_idx_d;
  logic        acc_b, cen_p, wen_p, cen_x, ofifo_rd, l0_rd, l0_wr, exec_b, load_b;
  logic [10:0] a_p, a_x;
`ifdef CORE_CTRL_ACC_PHASE_EN
  logic [7:0]  kj_q, kj_d;
  logic [10:0] ra_q, ra_d, pix_q, pix_d, ox_q, ox_d, onij_q, onij_d;
`endif

  always_comb begin
    state_d = state_q;
    t_d = t_q + 16'd1;
    kij_d = kij_q;
    wb_d = wb_q;
    pb_d = pb_q;
    acc_b = 1'b0;
    cen_p = 1'b1;
    wen_p = 1'b1;
    a_p = '0;
    cen_x = 1'b1;
    a_x = '0;
    ofifo_rd = 1'b0;
    l0_rd = 1'b0;
    l0_wr = 1'b0;
    exec_b = 1'b0;
    load_b = 1'b0;
    acc_clr_d = 1'b0;
    out_valid_d = 1'b0;
    out_idx_d = '0;
    done_d = 1'b0;
`ifdef CORE_CTRL_ACC_PHASE_EN
    kj_d = kj_q;
    ra_d = ra_q;
    pix_d = pix_q;
    ox_d = ox_q;
    onij_d = onij_q;
`endif
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        kij_d = '0;
        wb_d = W_BASE;
        pb_d = '0;
`ifdef CORE_CTRL_ACC_PHASE_EN
        pix_d = '0;
        ox_d = '0;
        onij_d = '0;
`endif
        state_d = start ? S_WL0 : S_IDLE;
      end
      S_WL0: begin
        cen_x = t_q == N_COL;
        a_x = cen_x ? 11'd0 : wb_q + t_q[10:0];
        l0_wr = t_q != '0;
        if (t_q == N_COL) begin
          state_d = S_WLD;
          t_d = '0;
        end
      end
      S_WLD: begin
        l0_rd = 1'b1;
        load_b = 1'b1;
        if (t_q == N_WLD) begin
          state_d = S_GAP;
          t_d = '0;
        end
      end
      S_GAP: begin
        if (t_q == N_GAP) begin
          state_d = S_XL0;
          t_d = '0;
        end
      end
      S_XL0: begin
        cen_x = t_q == N_NIJ;
        a_x = cen_x ? 11'd0 : t_q[10:0];
        l0_wr = t_q != '0;
        if (t_q == N_NIJ) begin
          state_d = S_EXE;
          t_d = '0;
        end
      end
      S_EXE: begin
        l0_rd = 1'b1;
        exec_b = t_q != '0;
        if (t_q == N_NIJ) begin
          state_d = S_EGAP;
          t_d = '0;
        end
      end
      S_EGAP: begin
        if (t_q == N_GAP) begin
          state_d = S_DWT;
          t_d = '0;
        end
      end
      S_DWT: begin
        t_d = '0;
        state_d = ofifo_valid ? S_DRN : S_DWT;
      end
      S_DRN: begin
        ofifo_rd = t_q != N_NIJ;
        cen_p = t_q == '0;
        wen_p = t_q == '0;
        a_p = cen_p ? 11'd0 : pb_q + t_q[10:0] - 11'd1;
        if (t_q == N_NIJ) begin
          t_d = '0;
          if (kij_q == KIJ_LAST) begin
            state_d = S_POST;
          end else begin
            state_d = S_WL0;
            kij_d = kij_q + 11'd1;
            wb_d = wb_q + A_COL;
            pb_d = pb_q + A_NIJ;
          end
        end
      end
`ifdef CORE_CTRL_ACC_PHASE_EN
      S_ACC: begin
        acc_clr_d = t_q == '0;
        cen_p = t_q == '0 || t_q > N_KIJ;
        a_p = cen_p ? 11'd0 : ra_q;
        acc_b = t_q >= 16'd2 && t_q <= N_ACC_END;
        out_valid_d = t_q == N_OV;
        out_idx_d = out_valid_d ? onij_q : 11'd0;
        if (t_q == '0) begin
          ra_d = pix_q;
          kj_d = '0;
        end else if (!cen_p) begin
          ra_d = ra_q + (kj_q == KJ_LAST ? A_ROW : A_NXT);
          kj_d = kj_q == KJ_LAST ? 8'd0 : kj_q + 8'd1;
        end
        if (out_valid_d) begin
          t_d = '0;
          onij_d = onij_q + 11'd1;
          ox_d = ox_q == OX_LAST ? 11'd0 : ox_q + 11'd1;
          pix_d = pix_q + (ox_q == OX_LAST ? A_K : 11'd1);
          state_d = onij_q == ONIJ_LAST ? S_FIN : S_ACC;
        end
      end
`endif
      S_FIN: begin
        done_d = 1'b1;
        t_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_q != S_IDLE;
    inst_d = {acc_b, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, ofifo_rd, 2'b00, l0_rd, l0_wr, exec_b, load_b};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      t_q <= '0;
      kij_q <= '0;
      wb_q <= W_BASE;
      pb_q <= '0;
      inst_q <= IDLE_INST;
      acc_clr_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      kij_q <= kij_d;
      wb_q <= wb_d;
      pb_q <= pb_d;
      inst_q <= inst_d;
      acc_clr_q <= acc_clr_d;
      out_valid_q <= out_valid_d;
      out_idx_q <= out_idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef CORE_CTRL_ACC_PHASE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      kj_q <= '0;
      ra_q <= '0;
      pix_q <= '0;
      ox_q <= '0;
      onij_q <= '0;
    end else begin
      kj_q <= kj_d;
      ra_q <= ra_d;
      pix_q <= pix_d;
      ox_q <= ox_d;
      onij_q <= onij_d;
    end
  end
`endif

  assign inst = inst_q;
  assign acc_clr = acc_clr_q;
  assign out_valid = out_valid_q;
  assign out_idx = out_idx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_core_ctrl_seq.sv
// tb_core_ctrl_seq: randomized bench comparing core_ctrl_seq against a phase-list model of a whole layer
module tb_core_ctrl_seq;
  localparam int COL = 8;
  localparam int I_DIM = 8;
  localparam int K_DIM = 3;
  localparam int GAP = 10;
  localparam int NIJ = I_DIM * I_DIM;
  localparam int LKIJ = K_DIM * K_DIM;
  localparam int O_DIM = I_DIM - K_DIM + 1;
  localparam logic [10:0] W_BASE = 11'h400;
  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
`ifdef CORE_CTRL_ACC_PHASE_EN
  localparam int EXP_OV = O_DIM * O_DIM;
  localparam int EXP_ACC = O_DIM * O_DIM * LKIJ;
`else
  localparam int EXP_OV = 0;
  localparam int EXP_ACC = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic acc_clr, out_valid, busy, done;
  logic [10:0] out_idx;

  core_ctrl_seq dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .acc_clr(acc_clr),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] inst;
    logic clr, ov;
    logic [10:0] idx;
    logic bz, dn, v;
  } exp_t;

  exp_t q[$];
  int wt[LKIJ];
  int exe_st[LKIJ];
  int checks = 0;
  int errors = 0;

  function automatic logic [33:0] mk(input bit acc, input bit pw, input bit pr, input logic [10:0] pa,
                                     input bit xr, input logic [10:0] xa, input bit ofrd,
                                     input bit l0rd, input bit l0wr, input bit ex, input bit ld);
    return {acc, ~(pw | pr), ~pw, pa, ~xr, 1'b1, xa, ofrd, 2'b00, l0rd, l0wr, ex, ld};
  endfunction

  function automatic void push(input logic [33:0] in, input bit clr, input bit ov, input logic [10:0] idx,
                               input bit bz, input bit dn, input bit v);
    exp_t e;
    e.inst = in;
    e.clr = clr;
    e.ov = ov;
    e.idx = idx;
    e.bz = bz;
    e.dn = dn;
    e.v = v;
    q.push_back(e);
  endfunction

  function automatic void build();
    q.delete();
    for (int k = 0; k < LKIJ; k++) begin
      for (int t = 0; t <= COL; t++)
        push(mk(0, 0, 0, '0, t < COL, t < COL ? 11'(int'(W_BASE) + k * COL + t) : 11'd0, 0, 0, t > 0, 0, 0), 0, 0, '0, 1, 0, 0);
      for (int t = 0; t < 2 * COL; t++) push(mk(0, 0, 0, '0, 0, '0, 0, 1, 0, 0, 1), 0, 0, '0, 1, 0, 0);
      for (int t = 0; t < GAP; t++) push(IDLE_I, 0, 0, '0, 1, 0, 0);
      for (int t = 0; t <= NIJ; t++)
        push(mk(0, 0, 0, '0, t < NIJ, t < NIJ ? 11'(t) : 11'd0, 0, 0, t > 0, 0, 0), 0, 0, '0, 1, 0, 0);
      exe_st[k] = q.size();
      for (int t = 0; t <= NIJ; t++) push(mk(0, 0, 0, '0, 0, '0, 0, 1, 0, t > 0, 0), 0, 0, '0, 1, 0, 0);
      for (int t = 0; t < GAP; t++) push(IDLE_I, 0, 0, '0, 1, 0, 0);
      for (int t = 0; t < wt[k]; t++) push(IDLE_I, 0, 0, '0, 1, 0, t >= wt[k] - 2);
      for (int t = 0; t <= NIJ; t++)
        push(mk(0, t > 0, 0, t > 0 ? 11'(k * NIJ + t - 1) : 11'd0, 0, '0, t < NIJ, 0, 0, 0, 0), 0, 0, '0, 1, 0, 0);
    end
`ifdef CORE_CTRL_ACC_PHASE_EN
    for (int oy = 0; oy < O_DIM; oy++)
      for (int ox = 0; ox < O_DIM; ox++)
        for (int t = 0; t < LKIJ + 3; t++) begin
          int kk = t - 1;
          bit rd = t >= 1 && t <= LKIJ;
          logic [10:0] pa = rd ? 11'(kk * NIJ + (oy + kk / K_DIM) * I_DIM + ox + kk % K_DIM) : 11'd0;
          push(mk(t >= 2 && t <= LKIJ + 1, 0, rd, pa, 0, '0, 0, 0, 0, 0, 0), t == 0, t == LKIJ + 2,
               t == LKIJ + 2 ? 11'(oy * O_DIM + ox) : 11'd0, 1, 0, 0);
        end
`endif
    push(IDLE_I, 0, 0, '0, 1, 1, 0);
    push(IDLE_I, 0, 0, '0, 0, 0, 0);
  endfunction

  task automatic run_layer(input int stop_at, input bit rnd_start, output int n_ov, output int n_acc);
    int n;
    n = (stop_at < 0) ? q.size() : stop_at + 1;
    n_ov = 0;
    n_acc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (inst !== IDLE_I || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: inst=%h busy=%b, expected inst=%h busy=0", inst, busy, IDLE_I);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({inst, acc_clr, out_valid, out_idx, busy, done} !==
          {q[i].inst, q[i].clr, q[i].ov, q[i].idx, q[i].bz, q[i].dn}) begin
        errors++;
        $display("FAIL trace[%0d]: got inst=%h clr=%b ov=%b idx=%0d busy=%b done=%b, expected inst=%h clr=%b ov=%b idx=%0d busy=%b done=%b",
                 i, inst, acc_clr, out_valid, out_idx, busy, done,
                 q[i].inst, q[i].clr, q[i].ov, q[i].idx, q[i].bz, q[i].dn);
      end
      n_ov += int'(out_valid);
      n_acc += int'(inst[33]);
      ofifo_valid = q[i].v;
      start = rnd_start && (i < q.size() - 2) && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
  endtask

  task automatic check_counts(input string name, input int n_ov, input int n_acc);
    checks++;
    if (n_ov !== EXP_OV) begin
      errors++;
      $display("FAIL %s out_valid_count: got %0d, expected %0d", name, n_ov, EXP_OV);
    end
    checks++;
    if (n_acc !== EXP_ACC) begin
      errors++;
      $display("FAIL %s acc_count: got %0d, expected %0d", name, n_acc, EXP_ACC);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      ofifo_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({inst, acc_clr, out_valid, out_idx, busy, done} !== {IDLE_I, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle: inst=%h clr=%b ov=%b idx=%0d busy=%b done=%b, expected inst=%h rest 0",
                 inst, acc_clr, out_valid, out_idx, busy, done, IDLE_I);
      end
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_weight_fetch();
    int n_ov, n_acc;
    for (int k = 0; k < LKIJ; k++) wt[k] = $urandom_range(2, 6);
    build();
    run_layer(-1, 1'b0, n_ov, n_acc);
    check_counts("weight_fetch", n_ov, n_acc);
  endtask

  task automatic test_drain_stall();
    int n_ov, n_acc;
    for (int k = 0; k < LKIJ; k++) wt[k] = $urandom_range(2, 8);
    wt[0] = 22;
    wt[LKIJ - 1] = 24;
    build();
    run_layer(-1, 1'b1, n_ov, n_acc);
    check_counts("drain_stall", n_ov, n_acc);
  endtask

  task automatic test_mid_reset();
    int n_ov, n_acc;
    for (int k = 0; k < LKIJ; k++) wt[k] = $urandom_range(2, 5);
    build();
    run_layer(exe_st[4] + 1 + $urandom_range(0, 40), 1'b1, n_ov, n_acc);
    reset = 1'b0;
    ofifo_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({inst, acc_clr, out_valid, out_idx, busy, done} !== {IDLE_I, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mid_reset_idle: inst=%h clr=%b ov=%b idx=%0d busy=%b done=%b, expected inst=%h rest 0",
                 inst, acc_clr, out_valid, out_idx, busy, done, IDLE_I);
      end
    end
    start = 1'b0;
    reset = 1'b1;
    run_layer(-1, 1'b0, n_ov, n_acc);
    check_counts("restart_after_reset", n_ov, n_acc);
  endtask

  task automatic test_back_to_back();
    int n_ov, n_acc;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < LKIJ; k++) wt[k] = $urandom_range(2, 4);
      build();
      run_layer(-1, 1'b1, n_ov, n_acc);
      check_counts("back_to_back", n_ov, n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_weight_fetch();
    test_drain_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
